// File: rtl/fa_str.sv
// -----------------------------------------------------------------------------
// fa_str : structural 1-bit full adder with optional output registers and a
//          bit-serial carry-feedback mode.
//
// The adder core is built from gate primitives: two half adders plus an OR.
// In serial mode the carry-in comes from an internal carry register, so a
// multi-bit word can be added one bit per enabled cycle, LSB first.
//
// Parameters
//   REG_OUT  1 = S/Cout come from registers (1-cycle latency)
//            0 = S/Cout are the combinational core outputs (zero latency)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset (priority over en)
//   en      in   register update enable; 0 holds every register
//   serial  in   1 = carry-in from internal carry register, C ignored
//   A, B    in   addend bits
//   C       in   carry-in in parallel mode
//   S_c     out  combinational core sum (always live)
//   Cout_c  out  combinational core carry (always live)
//   S       out  sum (registered when REG_OUT=1)
//   Cout    out  carry-out (registered when REG_OUT=1)
// -----------------------------------------------------------------------------
module fa_str #(
   parameter bit REG_OUT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic serial,
   input  logic A,
   input  logic B,
   input  logic C,
   output logic S_c,
   output logic Cout_c,
   output logic S,
   output logic Cout
);

   logic r_carry;
   logic w_cin;
   logic w_p;
   logic w_g1;
   logic w_g2;

   // The mux fully masks C in serial mode, so an undriven C cannot leak
   // into the sum while a word is being added serially.
   assign w_cin = serial ? r_carry : C;

   // Half adder 1: propagate / generate from the addend bits.
   xor u_ha1_xor (w_p,  A, B);
   and u_ha1_and (w_g1, A, B);

   // Half adder 2: fold in the carry-in.
   xor u_ha2_xor (S_c,  w_p, w_cin);
   and u_ha2_and (w_g2, w_p, w_cin);

   // Carry out of the full adder.
   or  u_cout_or (Cout_c, w_g1, w_g2);

   // Carry register feeds the serial path; it is clocked in both output
   // modes so serial addition works with combinational outputs too.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_carry <= 1'b0;
      end else if (en) begin
         r_carry <= Cout_c;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         logic r_s;
         logic r_cout;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_s    <= 1'b0;
               r_cout <= 1'b0;
            end else if (en) begin
               r_s    <= S_c;
               r_cout <= Cout_c;
            end
         end

         assign S    = r_s;
         assign Cout = r_cout;
      end else begin : g_comb_out
         assign S    = S_c;
         assign Cout = Cout_c;
      end
   endgenerate

endmodule

// File: tb/tb_fa_str.sv
// -----------------------------------------------------------------------------
// tb_fa_str : self-checking bench for fa_str.
// Instance dut1 uses registered outputs, dut0 uses combinational outputs.
// Expected {Cout,S} pairs for registered checks are pushed to a queue when the
// stimulus is driven and popped after the clock edge that produces them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fa_str;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-output instance signals.
   logic rst, en, serial, A, B, C;
   logic S_c, Cout_c, S, Cout;

   // Combinational-output instance signals.
   logic rst0, en0, serial0, A0, B0, C0;
   logic S_c0, Cout_c0, S0, Cout0;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] sb_q[$];   // expected {Cout,S} for registered outputs
   logic       m_carry;   // reference carry register for dut1

   fa_str #(.REG_OUT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .serial(serial),
      .A(A), .B(B), .C(C),
      .S_c(S_c), .Cout_c(Cout_c), .S(S), .Cout(Cout)
   );

   fa_str #(.REG_OUT(1'b0)) dut0 (
      .clk(clk), .rst(rst0), .en(en0), .serial(serial0),
      .A(A0), .B(B0), .C(C0),
      .S_c(S_c0), .Cout_c(Cout_c0), .S(S0), .Cout(Cout0)
   );

   // Arithmetic reference: {carry,sum} of three bits.
   function automatic logic [1:0] add3(input logic a, input logic b, input logic c);
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

   // Drive dut1 inputs on the falling edge, away from the sampling edge.
   task automatic drive(input logic a, input logic b, input logic c,
                        input logic ser, input logic e, input logic r);
      @(negedge clk);
      A = a; B = b; C = c; serial = ser; en = e; rst = r;
   endtask

   // Advance one rising edge, update the carry model, sample 1 ns later.
   task automatic tick();
      logic [1:0] cv;
      cv = add3(A, B, serial ? m_carry : C);
      @(posedge clk);
      if (rst)     m_carry = 1'b0;
      else if (en) m_carry = cv[1];
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] got;
      // Power-up reset already applied.
      got = {Cout, S};
      n_checks++;
      if (got !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_initial: got %b required 00", got);
      end
      // rst together with en=1 and all-ones inputs still clears.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      got = {Cout, S};
      n_checks++;
      if (got !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_over_en: got %b required 00", got);
      end
      // Release: 1+1+1 -> S=1, Cout=1 after the next edge.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      sb_q.push_back(add3(1'b1, 1'b1, 1'b1));
      tick();
      got = {Cout, S};
      n_checks++;
      if (got !== sb_q.pop_front()) begin
         n_errors++;
         $display("FAIL reset_release: got %b required 11", got);
      end
   endtask

   task automatic test_parallel();
      logic [1:0] exp_v, got;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] abc;
         abc = i[2:0];
         drive(abc[2], abc[1], abc[0], 1'b0, 1'b1, 1'b0);
         exp_v = add3(abc[2], abc[1], abc[0]);
         #1;
         got = {Cout_c, S_c};
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL parallel_comb abc=%b: got %b required %b", abc, got, exp_v);
         end
         sb_q.push_back(exp_v);
         tick();
         exp_v = sb_q.pop_front();
         got = {Cout, S};
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL parallel_reg abc=%b: got %b required %b", abc, got, exp_v);
         end
      end
   endtask

   task automatic test_enable_hold();
      logic [1:0] exp_v, got;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      sb_q.push_back(2'b10);
      tick();
      exp_v = sb_q.pop_front();
      got = {Cout, S};
      n_checks++;
      if (got !== exp_v) begin
         n_errors++;
         $display("FAIL hold_load: got %b required %b", got, exp_v);
      end
      // en=0 with new inputs: outputs must hold for two edges.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      got = {Cout, S};
      n_checks++;
      if (got !== 2'b10) begin
         n_errors++;
         $display("FAIL hold_en0: got %b required 10", got);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      sb_q.push_back(2'b01);
      tick();
      exp_v = sb_q.pop_front();
      got = {Cout, S};
      n_checks++;
      if (got !== exp_v) begin
         n_errors++;
         $display("FAIL hold_reenable: got %b required %b", got, exp_v);
      end
   endtask

   // 3 + 1 LSB-first: (1,1),(1,0),(0,0),(0,0) -> S 0,0,1,0 and carry 1,1,0,0.
   task automatic test_serial_add();
      logic [1:0] pairs [4];
      logic [1:0] exp_v, got;
      logic       cdrv;
      pairs[0] = 2'b11; pairs[1] = 2'b10; pairs[2] = 2'b00; pairs[3] = 2'b00;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         // C is unused in serial mode; drive it to X or 1 to prove masking.
         cdrv = (i % 2 == 0) ? 1'bx : 1'b1;
         drive(pairs[i][1], pairs[i][0], cdrv, 1'b1, 1'b1, 1'b0);
         exp_v = add3(pairs[i][1], pairs[i][0], m_carry);
         #1;
         got = {Cout_c, S_c};
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL serial_comb bit%0d: got %b required %b", i, got, exp_v);
         end
         sb_q.push_back(exp_v);
         tick();
         exp_v = sb_q.pop_front();
         got = {Cout, S};
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL serial_reg bit%0d: got %b required %b", i, got, exp_v);
         end
      end
   endtask

   task automatic test_serial_reset_mid();
      logic [1:0] got;
      // (1,1) sets the carry register.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      // carry=1, A=B=0: serial sum is 1; switching to parallel with C=0 drops it at once.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (S_c !== 1'b1) begin
         n_errors++;
         $display("FAIL serial_carry_used: got %b required 1", S_c);
      end
      serial = 1'b0;
      #1;
      n_checks++;
      if (S_c !== 1'b0) begin
         n_errors++;
         $display("FAIL serial_switch_off: got %b required 0", S_c);
      end
      // Reset mid-word, then (0,0) with C=1 in serial mode adds with cin=0.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      got = {Cout_c, S_c};
      n_checks++;
      if (got !== 2'b00) begin
         n_errors++;
         $display("FAIL serial_after_rst_comb: got %b required 00", got);
      end
      sb_q.push_back(2'b00);
      tick();
      got = {Cout, S};
      n_checks++;
      if (got !== sb_q.pop_front()) begin
         n_errors++;
         $display("FAIL serial_after_rst_reg: got %b required 00", got);
      end
   endtask

   task automatic test_comb_out();
      logic [1:0] exp_v, got;
      en0 = 1'b0; serial0 = 1'b0; rst0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] abc;
         abc = i[2:0];
         {A0, B0, C0} = abc;
         exp_v = add3(abc[2], abc[1], abc[0]);
         #1;
         got = {Cout0, S0};
         n_checks++;
         if (got !== exp_v) begin
            n_errors++;
            $display("FAIL comb_out abc=%b: got %b required %b", abc, got, exp_v);
         end
         #4;
      end
      // Serial mode still works with combinational outputs.
      @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0; en0 = 1'b1; serial0 = 1'b1; A0 = 1'b1; B0 = 1'b1; C0 = 1'b0;
      @(negedge clk);
      en0 = 1'b0; A0 = 1'b0; B0 = 1'b0;
      #1;
      got = {Cout0, S0};
      n_checks++;
      if (got !== 2'b01) begin
         n_errors++;
         $display("FAIL comb_serial_carry: got %b required 01", got);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; serial = 1'b0; A = 1'b0; B = 1'b0; C = 1'b0;
      rst0 = 1'b1; en0 = 1'b0; serial0 = 1'b0; A0 = 1'b0; B0 = 1'b0; C0 = 1'b0;
      m_carry = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_parallel();
      test_enable_hold();
      test_serial_add();
      test_serial_reset_mid();
      test_comb_out();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
